// File: rtl/rlsecbuf_pkg.sv
// Shared constants and helpers for the RL11 single-sector write-back buffer.
// State encodings are plain constants so older tools can consume them.
package rlsecbuf_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOOKUP = 3'd1;
  localparam logic [2:0] ST_WB     = 3'd2;
  localparam logic [2:0] ST_FILL   = 3'd3;
  localparam logic [2:0] ST_ACCESS = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  localparam int LOGSECT_DEF = 8;

  function automatic int wps_of(input int logsect);
    return 1 << (logsect - 2);
  endfunction

  // Little-endian lanes: half=0 is bits [15:0], half=1 is bits [31:16].
  function automatic logic [15:0] lane_sel(input logic [31:0] word, input logic half);
    return half ? word[31:16] : word[15:0];
  endfunction

  function automatic logic [1:0] lane_we(input logic half);
    return half ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rlsecbuf_ram.sv
// Sector store: synchronous-read RAM of 32-bit words with per-half write enables.
module rlsecbuf_ram #(
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [1:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we_i[0]) mem_q[addr_i][15:0]  <= wdata_i[15:0];
    if (we_i[1]) mem_q[addr_i][31:16] <= wdata_i[31:16];
    rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/rlsecbuf.sv
// Single-sector write-back buffer: turns RL11 16-bit word accesses into
// whole-sector 32-bit bursts on the backing-store port.
module rlsecbuf
  import rlsecbuf_pkg::*;
#(
  parameter int LOGSECT = LOGSECT_DEF
) (
  input  logic        clk,
  input  logic        busrst_n,
  input  logic        rlmemreq,
  input  logic        rlmemwr,
  input  logic [31:0] rlmemaddr,
  input  logic [15:0] rlmemwdata,
  output logic        rlmemack,
  output logic [15:0] rlmemrdata,
  output logic        bsreq,
  output logic        bswr,
  output logic [31:0] bsaddr,
  output logic [31:0] bswdata,
  input  logic        bsack,
  input  logic [31:0] bsrdata,
  input  logic        flush,
  output logic        busy
);

  localparam int IW  = LOGSECT - 2;
  localparam int WPS = wps_of(LOGSECT);
  localparam int TW  = 32 - LOGSECT;
  localparam logic [IW:0] CNT_END = (IW+1)'(WPS);

  logic [2:0]    state_q, state_d;
  logic          valid_q, valid_d, dirty_q, dirty_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          req_pend_q, req_pend_d, flush_pend_q, flush_pend_d;
  logic          wb_flush_q, wb_flush_d;
  logic [31:0]   addr_q, addr_d;
  logic          wr_q, wr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [IW:0]   cnt_q, cnt_d;
  logic          prime_q, prime_d, out_q, out_d;
  logic          ack_q, ack_d, bsreq_q, bsreq_d, bswr_q, bswr_d, busy_q, busy_d;
  logic [15:0]   rdata_q, rdata_d;
  logic [31:0]   bsaddr_q, bsaddr_d, bswdata_q, bswdata_d;

  logic [IW-1:0] ram_addr_s;
  logic [1:0]    ram_we_s;
  logic [31:0]   ram_wdata_s, ram_rdata_s;
  logic          hit_s, bs_ack_s, unused_ok_s;

  assign unused_ok_s = rlmemaddr[0];
  assign hit_s    = valid_q && (tag_q == addr_q[31:LOGSECT]);
  // An ack with nothing outstanding (e.g. straggler after reset) is ignored.
  assign bs_ack_s = bsack && out_q;

  rlsecbuf_ram #(.AW(IW)) u_ram (
    .clk     (clk),
    .addr_i  (ram_addr_s),
    .we_i    (ram_we_s),
    .wdata_i (ram_wdata_s),
    .rdata_o (ram_rdata_s)
  );

  // Next-state logic for the FSM, burst engine and request latches.
  always_comb begin
    state_d = state_q;  valid_d = valid_q;  dirty_d = dirty_q;  tag_d = tag_q;
    req_pend_d = req_pend_q;  flush_pend_d = flush_pend_q;  wb_flush_d = wb_flush_q;
    addr_d = addr_q;  wr_d = wr_q;  wdata_d = wdata_q;
    cnt_d = cnt_q;  prime_d = prime_q;  out_d = out_q;
    ack_d = 1'b0;  bsreq_d = 1'b0;  bswr_d = bswr_q;  rdata_d = rdata_q;
    bsaddr_d = bsaddr_q;  bswdata_d = bswdata_q;
    ram_addr_s  = addr_q[LOGSECT-1:2];
    ram_we_s    = 2'b00;
    ram_wdata_s = {wdata_q, wdata_q};

    if (rlmemreq) begin
      req_pend_d = 1'b1;
      addr_d     = rlmemaddr;
      wr_d       = rlmemwr;
      wdata_d    = rlmemwdata;
    end else begin
      req_pend_d = req_pend_q;
    end
    if (flush) flush_pend_d = 1'b1;
    else       flush_pend_d = flush_pend_q;

    case (state_q)
      ST_IDLE: begin
        if (rlmemreq || req_pend_q) begin
          state_d    = ST_LOOKUP;
          req_pend_d = 1'b0;
        end else if (flush_pend_q) begin
          flush_pend_d = flush;
          if (dirty_q) begin
            state_d    = ST_WB;
            wb_flush_d = 1'b1;
            cnt_d      = '0;
            prime_d    = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOOKUP: begin
        if (hit_s) begin
          state_d = ST_ACCESS;
        end else if (dirty_q) begin
          state_d    = ST_WB;
          wb_flush_d = 1'b0;
          cnt_d      = '0;
          prime_d    = 1'b1;
        end else begin
          state_d = ST_FILL;
          cnt_d   = '0;
        end
      end
      // Each word needs one idle cycle (prime) for the synchronous RAM read.
      ST_WB: begin
        ram_addr_s = cnt_q[IW-1:0];
        if (bs_ack_s) begin
          out_d   = 1'b0;
          cnt_d   = cnt_q + (IW+1)'(1);
          prime_d = 1'b1;
        end else if (out_q) begin
          out_d = 1'b1;
        end else if (prime_q) begin
          prime_d = 1'b0;
        end else if (cnt_q == CNT_END) begin
          dirty_d = 1'b0;
          if (wb_flush_q) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FILL;
            cnt_d   = '0;
          end
        end else begin
          bsreq_d   = 1'b1;
          bswr_d    = 1'b1;
          bsaddr_d  = {tag_q, cnt_q[IW-1:0], 2'b00};
          bswdata_d = ram_rdata_s;
          out_d     = 1'b1;
        end
      end
      ST_FILL: begin
        if (bs_ack_s) begin
          ram_addr_s  = cnt_q[IW-1:0];
          ram_we_s    = 2'b11;
          ram_wdata_s = bsrdata;
          out_d       = 1'b0;
          cnt_d       = cnt_q + (IW+1)'(1);
        end else if (out_q) begin
          out_d = 1'b1;
        end else if (cnt_q == CNT_END) begin
          valid_d = 1'b1;
          tag_d   = addr_q[31:LOGSECT];
          state_d = ST_ACCESS;
        end else begin
          bsreq_d  = 1'b1;
          bswr_d   = 1'b0;
          bsaddr_d = {addr_q[31:LOGSECT], cnt_q[IW-1:0], 2'b00};
          out_d    = 1'b1;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        ack_d   = 1'b1;
        if (wr_q) begin
          ram_we_s = lane_we(addr_q[1]);
          dirty_d  = 1'b1;
        end else begin
          rdata_d = lane_sel(ram_rdata_s, addr_q[1]);
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE) || req_pend_d || flush_pend_d;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!busrst_n) begin
      state_q <= ST_IDLE;  valid_q <= 1'b0;  dirty_q <= 1'b0;  tag_q <= '0;
      req_pend_q <= 1'b0;  flush_pend_q <= 1'b0;  wb_flush_q <= 1'b0;
      addr_q <= '0;  wr_q <= 1'b0;  wdata_q <= '0;
      cnt_q <= '0;  prime_q <= 1'b0;  out_q <= 1'b0;
      ack_q <= 1'b0;  bsreq_q <= 1'b0;  bswr_q <= 1'b0;  busy_q <= 1'b0;
      rdata_q <= '0;  bsaddr_q <= '0;  bswdata_q <= '0;
    end else begin
      state_q <= state_d;  valid_q <= valid_d;  dirty_q <= dirty_d;  tag_q <= tag_d;
      req_pend_q <= req_pend_d;  flush_pend_q <= flush_pend_d;  wb_flush_q <= wb_flush_d;
      addr_q <= addr_d;  wr_q <= wr_d;  wdata_q <= wdata_d;
      cnt_q <= cnt_d;  prime_q <= prime_d;  out_q <= out_d;
      ack_q <= ack_d;  bsreq_q <= bsreq_d;  bswr_q <= bswr_d;  busy_q <= busy_d;
      rdata_q <= rdata_d;  bsaddr_q <= bsaddr_d;  bswdata_q <= bswdata_d;
    end
  end

  assign rlmemack   = ack_q;
  assign rlmemrdata = rdata_q;
  assign bsreq      = bsreq_q;
  assign bswr       = bswr_q;
  assign bsaddr     = bsaddr_q;
  assign bswdata    = bswdata_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_rlsecbuf.sv
// Scoreboard bench for rlsecbuf: stimulus pushes expected bs transactions and
// acks into queues; monitors pop and compare as the DUT presents them.
module tb_rlsecbuf;

  logic        clk = 1'b0;
  logic        busrst_n, rlmemreq, rlmemwr, bsack, flush;
  logic [31:0] rlmemaddr, bsrdata;
  logic [15:0] rlmemwdata;
  logic        rlmemack, bsreq, bswr, busy;
  logic [15:0] rlmemrdata;
  logic [31:0] bsaddr, bswdata;

  typedef struct packed {logic wr; logic [31:0] a; logic [31:0] d;} bs_t;
  bs_t         exp_bs[$];
  logic [15:0] exp_ack[$];
  logic [31:0] model [0:63];

  int n_err = 0, n_checks = 0, cyc = 0;
  int bs_seen = 0, ack_seen = 0, ack_base = 0, last_ack_cyc = 0, req_cyc = 0;

  rlsecbuf #(.LOGSECT(8)) dut (
    .clk(clk), .busrst_n(busrst_n), .rlmemreq(rlmemreq), .rlmemwr(rlmemwr),
    .rlmemaddr(rlmemaddr), .rlmemwdata(rlmemwdata), .rlmemack(rlmemack),
    .rlmemrdata(rlmemrdata), .bsreq(bsreq), .bswr(bswr), .bsaddr(bsaddr),
    .bswdata(bswdata), .bsack(bsack), .bsrdata(bsrdata), .flush(flush), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return (a == 32'h0000_0300) ? 32'hBEEF_CAFE : {~a[15:0], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every bsreq and rlmemack must match the head of its queue.
  always @(negedge clk) begin
    if (busrst_n) begin
      if (bsreq) begin
        bs_seen++;
        if (exp_bs.size() == 0) chk("bs_unexpected", bsaddr, 32'hFFFF_FFFF);
        else begin
          bs_t e;
          e = exp_bs.pop_front();
          chk("bs_wr", {31'd0, bswr}, {31'd0, e.wr});
          chk("bs_addr", bsaddr, e.a);
          if (e.wr) chk("bs_wdata", bswdata, e.d);
        end
      end
      if (rlmemack) begin
        ack_seen++;
        last_ack_cyc = cyc;
        if (exp_ack.size() == 0) chk("ack_unexpected", {16'd0, rlmemrdata}, 32'hFFFF_FFFF);
        else chk("ack_rdata", {16'd0, rlmemrdata}, {16'd0, exp_ack.pop_front()});
      end
    end
  end

  // Backing store: acks two cycles after a request, checks the request is held.
  initial begin
    int   wait_n;
    logic stale;
    logic [31:0] held_a;
    bsack = 1'b0; bsrdata = 32'd0; wait_n = 0; stale = 1'b0; held_a = 32'd0;
    forever begin
      @(negedge clk);
      bsack = 1'b0;
      if (!busrst_n) stale = 1'b1;
      if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          if (!stale) chk("bs_hold_addr", bsaddr, held_a);
          bsack   = 1'b1;
          bsrdata = pat(held_a);
        end
      end else if (bsreq && busrst_n) begin
        held_a = bsaddr;
        stale  = 1'b0;
        wait_n = 2;
      end
    end
  end

  task automatic push_fill(input logic [31:0] base);
    bs_t e;
    for (int i = 0; i < 64; i++) begin
      e.wr = 1'b0; e.a = base + 32'(i*4); e.d = 32'd0;
      exp_bs.push_back(e);
      model[i] = pat(base + 32'(i*4));
    end
  endtask

  task automatic push_wb(input logic [31:0] base, input int n);
    bs_t e;
    for (int i = 0; i < n; i++) begin
      e.wr = 1'b1; e.a = base + 32'(i*4); e.d = model[i];
      exp_bs.push_back(e);
    end
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [15:0] d,
                        input logic fl);
    @(posedge clk); #1;
    ack_base = ack_seen;
    req_cyc  = cyc;
    rlmemreq = 1'b1; rlmemwr = wr; rlmemaddr = a; rlmemwdata = d; flush = fl;
    if (wr) begin
      if (a[1]) model[a[7:2]][31:16] = d;
      else      model[a[7:2]][15:0]  = d;
    end
    @(posedge clk); #1;
    rlmemreq = 1'b0; flush = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    for (int i = 0; i < 3000 && ack_seen == ack_base; i++) @(posedge clk);
    #1;
    chk(name, 32'(ack_seen - ack_base), 32'd1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 3000 && busy; i++) @(posedge clk);
    #1;
    chk(name, {31'd0, busy}, 32'd0);
    chk({name, "_drained"}, 32'(exp_bs.size()), 32'd0);
  endtask

  task automatic pulse_flush;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
  endtask

  initial begin
    int bs0;
    logic found;
    busrst_n = 1'b0; rlmemreq = 1'b0; rlmemwr = 1'b0; rlmemaddr = 32'd0;
    rlmemwdata = 16'd0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ack", {31'd0, rlmemack}, 32'd0);
    chk("rst_bsreq", {31'd0, bsreq}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", {16'd0, rlmemrdata}, 32'd0);
    chk("rst_bsaddr", bsaddr, 32'd0);
    chk("rst_bswdata", bswdata, 32'd0);
    chk("rst_bswr", {31'd0, bswr}, 32'd0);
    busrst_n = 1'b1;

    // Cold read: clean miss, 64 reads then low half of word 0.
    push_fill(32'h300); exp_ack.push_back(16'hCAFE);
    do_req(1'b0, 32'h300, 16'h0, 1'b0);
    wait_ack("cold_ack"); wait_idle("cold_idle");

    // Hit: upper half, exactly 3 cycles, no bs traffic.
    bs0 = bs_seen; exp_ack.push_back(16'hBEEF);
    do_req(1'b0, 32'h302, 16'h0, 1'b0);
    chk("hit_busy", {31'd0, busy}, 32'd1);
    wait_ack("hit_ack");
    chk("hit_latency", 32'(last_ack_cyc - req_cyc), 32'd3);
    chk("hit_no_bs", 32'(bs_seen), 32'(bs0));

    // Write hit leaves rdata unchanged; then dirty eviction by reading 0x400.
    exp_ack.push_back(16'hBEEF);
    do_req(1'b1, 32'h304, 16'h1234, 1'b0);
    wait_ack("wr_ack");
    push_wb(32'h300, 64); push_fill(32'h400); exp_ack.push_back(16'h0400);
    do_req(1'b0, 32'h400, 16'h0, 1'b0);
    wait_ack("evict_ack"); wait_idle("evict_idle");

    // Flush of a dirty sector, then a redundant flush.
    exp_ack.push_back(16'h0400);
    do_req(1'b1, 32'h402, 16'h5A5A, 1'b0);
    wait_ack("wr2_ack");
    push_wb(32'h400, 64);
    pulse_flush();
    wait_idle("flush_idle");
    bs0 = bs_seen;
    pulse_flush();
    repeat (20) @(posedge clk);
    #1;
    chk("flush_clean_no_bs", 32'(bs_seen), 32'(bs0));
    chk("flush_clean_busy", {31'd0, busy}, 32'd0);

    // Flush and read hit in the same cycle: ack first, then write-back.
    exp_ack.push_back(16'h0400);
    do_req(1'b1, 32'h408, 16'h1111, 1'b0);
    wait_ack("wr3_ack");
    exp_ack.push_back(16'h1111); push_wb(32'h400, 64);
    bs0 = bs_seen;
    do_req(1'b0, 32'h408, 16'h0, 1'b1);
    wait_ack("fr_ack");
    chk("fr_ack_before_wb", 32'(bs_seen), 32'(bs0));
    wait_idle("fr_idle");

    // Reset during write-back word 10, then the old sector must miss clean.
    exp_ack.push_back(16'h1111);
    do_req(1'b1, 32'h40C, 16'h2222, 1'b0);
    wait_ack("wr4_ack");
    push_wb(32'h400, 11);
    do_req(1'b0, 32'h500, 16'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 3000 && !found; i++) begin
      @(negedge clk); #1;
      if (bsreq && bsaddr == 32'h428) found = 1'b1;
    end
    chk("rst_wb10_found", {31'd0, found}, 32'd1);
    busrst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_bsreq", {31'd0, bsreq}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_bsaddr", bsaddr, 32'd0);
    chk("midrst_drained", 32'(exp_bs.size()), 32'd0);
    @(posedge clk); #1;
    busrst_n = 1'b1;
    repeat (4) @(posedge clk);
    exp_bs.delete(); exp_ack.delete();
    push_fill(32'h400); exp_ack.push_back(16'h0400);
    do_req(1'b0, 32'h400, 16'h0, 1'b0);
    wait_ack("post_rst_ack"); wait_idle("post_rst_idle");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
